// File: rtl/dm_cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dm_cache_mem_arbiter
// Purpose  : Round-robin arbiter sharing one memory port between the I-cache
//            (requester 0) and D-cache (requester 1); one transaction in flight.
// Revision : 1.0
// ============================================================================
module dm_cache_mem_arbiter #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int WRITE_DATA    = 32,
    parameter int WRITE_STROBE  = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,

    input  logic                     i_c0_valid,
    input  logic                     i_c0_rd_wr,
    input  logic [ADDRESS_WIDTH-1:0] i_c0_address,
    output logic                     o_c0_ready,
    input  logic [WRITE_DATA-1:0]    i_c0_write_data,
    input  logic [WRITE_STROBE-1:0]  i_c0_write_strobe,
    output logic [WRITE_DATA-1:0]    o_c0_read_data,
    output logic                     o_c0_read_valid,
    input  logic                     i_c0_read_ready,

    input  logic                     i_c1_valid,
    input  logic                     i_c1_rd_wr,
    input  logic [ADDRESS_WIDTH-1:0] i_c1_address,
    output logic                     o_c1_ready,
    input  logic [WRITE_DATA-1:0]    i_c1_write_data,
    input  logic [WRITE_STROBE-1:0]  i_c1_write_strobe,
    output logic [WRITE_DATA-1:0]    o_c1_read_data,
    output logic                     o_c1_read_valid,
    input  logic                     i_c1_read_ready,

    output logic                     o_mem_valid,
    output logic                     o_mem_rd_wr,
    output logic [ADDRESS_WIDTH-1:0] o_mem_address,
    input  logic                     i_mem_ready,
    output logic [WRITE_DATA-1:0]    o_mem_write_data,
    output logic [WRITE_STROBE-1:0]  o_mem_write_strobe,
    input  logic [WRITE_DATA-1:0]    i_mem_read_data,
    input  logic                     i_mem_read_valid,
    output logic                     o_mem_read_ready,

    output logic                     o_grant,
    output logic                     o_busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   gnt_q, gnt_d;
    logic   prio_q, prio_d;

    logic                     w_sel_valid;
    logic                     w_sel_rd_wr;
    logic [ADDRESS_WIDTH-1:0] w_sel_address;
    logic [WRITE_DATA-1:0]    w_sel_write_data;
    logic [WRITE_STROBE-1:0]  w_sel_write_strobe;
    logic                     w_sel_read_ready;

    assign w_sel_valid        = gnt_q ? i_c1_valid        : i_c0_valid;
    assign w_sel_rd_wr        = gnt_q ? i_c1_rd_wr        : i_c0_rd_wr;
    assign w_sel_address      = gnt_q ? i_c1_address      : i_c0_address;
    assign w_sel_write_data   = gnt_q ? i_c1_write_data   : i_c0_write_data;
    assign w_sel_write_strobe = gnt_q ? i_c1_write_strobe : i_c0_write_strobe;
    assign w_sel_read_ready   = gnt_q ? i_c1_read_ready   : i_c0_read_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            gnt_q   <= 1'b0;
            prio_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            prio_q  <= prio_d;
        end
    end

    always_comb begin
        state_d            = state_q;
        gnt_d              = gnt_q;
        prio_d             = prio_q;
        o_mem_valid        = 1'b0;
        o_mem_rd_wr        = 1'b0;
        o_mem_address      = '0;
        o_mem_write_data   = '0;
        o_mem_write_strobe = '0;
        o_c0_ready         = 1'b0;
        o_c1_ready         = 1'b0;
        o_c0_read_valid    = 1'b0;
        o_c1_read_valid    = 1'b0;
        o_mem_read_ready   = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Grant is registered here so no input reaches it combinationally
                if (i_c0_valid || i_c1_valid) begin
                    gnt_d   = (i_c0_valid && i_c1_valid) ? prio_q : i_c1_valid;
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                o_mem_valid        = w_sel_valid;
                o_mem_rd_wr        = w_sel_rd_wr;
                o_mem_address      = w_sel_address;
                o_mem_write_data   = w_sel_write_data;
                o_mem_write_strobe = w_sel_write_strobe;
                o_c0_ready         = !gnt_q && i_mem_ready;
                o_c1_ready         =  gnt_q && i_mem_ready;
                // A withdrawn request abandons the grant without rotating priority
                if (!w_sel_valid) begin
                    state_d = S_IDLE;
                end else if (i_mem_ready) begin
                    if (w_sel_rd_wr) begin
                        state_d = S_IDLE;
                        prio_d  = ~gnt_q;
                    end else begin
                        state_d = S_RESP;
                    end
                end
            end
            S_RESP: begin
                o_c0_read_valid  = !gnt_q && i_mem_read_valid;
                o_c1_read_valid  =  gnt_q && i_mem_read_valid;
                o_mem_read_ready = w_sel_read_ready;
                if (i_mem_read_valid && w_sel_read_ready) begin
                    state_d = S_IDLE;
                    prio_d  = ~gnt_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign o_c0_read_data = i_mem_read_data;
    assign o_c1_read_data = i_mem_read_data;
    assign o_grant        = gnt_q;
    assign o_busy         = (state_q != S_IDLE);

endmodule
`default_nettype wire
